// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // Width of the byte-lane offset within one XLEN-wide bus beat.
  function automatic int unsigned lane_off_w(input int unsigned xlen);
    return $clog2(xlen / 8);
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data lane selection followed by sign or zero extension to XLEN.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0]               rdata,
  input  logic [lane_off_w(XLEN)-1:0]   off,
  input  logic [2:0]                    funct3,
  output logic [XLEN-1:0]               data
);

  logic [XLEN-1:0] lane;

  always_comb begin
    lane = rdata >> {off, 3'b000};
    data = '0;
    case (funct3)
      F3_B:    data = XLEN'($signed(lane[7:0]));
      F3_H:    data = XLEN'($signed(lane[15:0]));
      F3_W:    data = XLEN'($signed(lane[31:0]));
      F3_D:    data = lane;
      F3_BU:   data = XLEN'(lane[7:0]);
      F3_HU:   data = XLEN'(lane[15:0]);
      F3_WU:   data = XLEN'(lane[31:0]);
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: latches one core access, formats it for the memory bus,
// waits for grant / read data with a timeout, and returns a one-cycle response.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int unsigned OFF_W = lane_off_w(XLEN);
  localparam int unsigned BE_W  = XLEN / 8;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  lsu_state_e state, state_nxt;

  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   rdata_q;
  logic              err_q;
  logic [CNT_W-1:0]  wait_cnt;

  logic              accept;
  logic              legal;
  logic              misaligned;
  logic              bad;
  logic              timeout;
  logic [OFF_W-1:0]  off_q;
  logic [XLEN-1:0]   load_data;
  logic [BE_W-1:0]   be_mask;
  logic [XLEN-1:0]   wdata_rep;

  assign req_ready = (state == IDLE) && reset_n;
  assign accept    = req_valid && req_ready;
  assign bad       = !legal || misaligned;
  assign off_q     = addr_q[OFF_W-1:0];
  assign timeout   = (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    legal = 1'b0;
    if (req_we) begin
      case (req_funct3)
        F3_B, F3_H, F3_W: legal = 1'b1;
        F3_D:             legal = (XLEN == 64);
        default:          legal = 1'b0;
      endcase
    end else begin
      case (req_funct3)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: legal = 1'b1;
        F3_D, F3_WU:                    legal = (XLEN == 64);
        default:                        legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    misaligned = 1'b0;
    case (req_funct3[1:0])
      2'd1:    misaligned = req_addr[0];
      2'd2:    misaligned = |req_addr[1:0];
      2'd3:    misaligned = |req_addr[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = bad ? RESP : REQ;
      REQ:     if (mem_gnt) state_nxt = we_q ? RESP : WAIT;
      WAIT:    if (mem_rvalid || timeout) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q     <= 1'b0;
      f3_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            err_q   <= bad;
            rdata_q <= '0;
          end
        end
        REQ: begin
          if (mem_gnt && !we_q) wait_cnt <= '0;
        end
        WAIT: begin
          if (mem_rvalid) begin
            rdata_q <= load_data;
          end else if (timeout) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (f3_q[1:0])
      2'd0:    be_mask = BE_W'(8'h01);
      2'd1:    be_mask = BE_W'(8'h03);
      2'd2:    be_mask = BE_W'(8'h0F);
      default: be_mask = BE_W'(8'hFF);
    endcase
    case (f3_q[1:0])
      2'd0:    wdata_rep = {(XLEN/8){wdata_q[7:0]}};
      2'd1:    wdata_rep = {(XLEN/16){wdata_q[15:0]}};
      2'd2:    wdata_rep = {(XLEN/32){wdata_q[31:0]}};
      default: wdata_rep = wdata_q;
    endcase
  end

  // Bus fields are driven only while requesting, so they read zero in reset and idle.
  assign mem_req    = (state == REQ);
  assign mem_we     = mem_req && we_q;
  assign mem_addr   = mem_req ? {addr_q[ADDR_W-1:OFF_W], OFF_W'(0)} : '0;
  assign mem_be     = mem_req ? (be_mask << off_q) : '0;
  assign mem_wdata  = mem_we ? wdata_rep : '0;

  assign resp_valid = (state == RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = resp_valid ? rdata_q : '0;

  lsu_load_align #(
    .XLEN(XLEN)
  ) u_load_align (
    .rdata  (mem_rdata),
    .off    (off_q),
    .funct3 (f3_q),
    .data   (load_data)
  );

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: 32-bit instance with a bus responder, plus a 64-bit instance.
module tb_lsu;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_gnt = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h80FF_1234;

  logic        d_req_valid = 1'b0;
  logic        d_req_ready;
  logic [2:0]  d_req_funct3 = '0;
  logic [31:0] d_req_addr = '0;
  logic [63:0] d_req_wdata = '0;
  logic        d_resp_valid;
  logic [63:0] d_resp_rdata;
  logic        d_resp_err;
  logic        d_mem_req;
  logic        d_mem_we;
  logic [31:0] d_mem_addr;
  logic [7:0]  d_mem_be;
  logic [63:0] d_mem_wdata;
  logic [63:0] d_mem_rdata = 64'h8765_4321_0000_0000;

  always #5 clk = ~clk;

  lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT(TO)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  // gnt and rvalid tied high: both are ignored outside REQ / WAIT.
  lsu #(.XLEN(64), .ADDR_W(32), .TIMEOUT(TO)) u_dut64 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(d_req_valid), .req_ready(d_req_ready), .req_we(1'b0),
    .req_funct3(d_req_funct3), .req_addr(d_req_addr), .req_wdata(d_req_wdata),
    .resp_valid(d_resp_valid), .resp_rdata(d_resp_rdata), .resp_err(d_resp_err),
    .mem_req(d_mem_req), .mem_gnt(1'b1), .mem_we(d_mem_we), .mem_addr(d_mem_addr),
    .mem_be(d_mem_be), .mem_wdata(d_mem_wdata), .mem_rvalid(1'b1), .mem_rdata(d_mem_rdata)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   resp_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus responder
  int   gnt_dly = 0;
  int   rv_dly = 0;
  int   stall = 0;
  int   rv_cnt = 0;
  int   req_cnt = 0;
  bit   pending = 0;
  logic gnt_we = 1'b0;

  always @(negedge clk) begin
    mem_rvalid = 1'b0;
    if (mem_gnt) begin
      mem_gnt = 1'b0;
      if (!gnt_we) begin
        pending = 1;
        rv_cnt  = 0;
      end
    end else if (mem_req) begin
      req_cnt++;
      if (stall >= gnt_dly) begin
        mem_gnt = 1'b1;
        gnt_we  = mem_we;
        stall   = 0;
      end else begin
        stall++;
      end
    end
    if (pending) begin
      if (rv_dly >= 0 && rv_cnt == rv_dly) begin
        mem_rvalid = 1'b1;
        pending    = 0;
      end
      rv_cnt++;
    end
  end

  // Response monitor
  always @(negedge clk) begin
    if (resp_valid) begin
      exp_t e;
      resp_cnt++;
      if (sb_q.size() == 0) begin
        check("unexpected_resp", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_err", resp_err, e.err);
        check("resp_cycle", cyc, e.cyc);
        check("ready_in_resp", req_ready, 0);
      end
    end
  end

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic exp_err, input int lat, input bit push);
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    if (i == 200) check("ready_wait", 0, 1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    if (push) sb_q.push_back('{rdata: exp_rd, err: exp_err, cyc: cyc + lat});
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_we     = $urandom_range(0, 1);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && req_ready) break;
    end
    if (i == 100) begin
      check("resp_timeout", sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  task automatic do64(input logic [2:0] f3, input logic [63:0] exp_rd);
    int n;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (d_req_ready) break;
    end
    d_req_valid  = 1'b1;
    d_req_funct3 = f3;
    d_req_addr   = 32'h5004;
    @(posedge clk);
    #1;
    d_req_valid = 1'b0;
    d_req_addr  = $urandom;
    for (n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (d_mem_req) begin
        check("d64_mem_be", d_mem_be, 8'hF0);
        check("d64_mem_addr", d_mem_addr, 32'h5000);
      end
      if (d_resp_valid) break;
    end
    check("d64_latency", n, 3);
    check("d64_rdata", d_resp_rdata, exp_rd);
    check("d64_err", d_resp_err, 0);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    int          gd;
    int          rd;
    logic [31:0] exp_rd;
    logic        err;
    logic [3:0]  be;
    logic [31:0] ma;
    logic [31:0] mwd;
    int          lat;
  } vec_t;

  // mem_rdata = 0x80FF_1234: lanes 3..0 = 80 FF 12 34
  vec_t vecs[] = '{
    '{0, 3'b000, 32'h1003, 32'h0,        0, 0, 32'hFFFF_FF80, 0, 4'b1000, 32'h1000, 32'h0,        3},
    '{0, 3'b001, 32'h1002, 32'h0,        0, 0, 32'hFFFF_80FF, 0, 4'b1100, 32'h1000, 32'h0,        3},
    '{0, 3'b101, 32'h1000, 32'h0,        1, 0, 32'h0000_1234, 0, 4'b0011, 32'h1000, 32'h0,        4},
    '{0, 3'b010, 32'h1000, 32'h0,        0, 2, 32'h80FF_1234, 0, 4'b1111, 32'h1000, 32'h0,        5},
    '{0, 3'b100, 32'h1002, 32'h0,        0, 0, 32'h0000_00FF, 0, 4'b0100, 32'h1000, 32'h0,        3},
    '{0, 3'b000, 32'h1001, 32'h0,        0, 0, 32'h0000_0012, 0, 4'b0010, 32'h1000, 32'h0,        3},
    '{1, 3'b001, 32'h2002, 32'h0000_BEEF,0, 0, 32'h0,         0, 4'b1100, 32'h2000, 32'hBEEF_BEEF, 2},
    '{1, 3'b000, 32'h2001, 32'h1234_56A5,0, 0, 32'h0,         0, 4'b0010, 32'h2000, 32'hA5A5_A5A5, 2},
    '{1, 3'b010, 32'h2004, 32'hDEAD_BEEF,2, 0, 32'h0,         0, 4'b1111, 32'h2004, 32'hDEAD_BEEF, 4},
    '{0, 3'b010, 32'h3001, 32'h0,        0, 0, 32'h0,         1, 4'b0000, 32'h0,    32'h0,        1},
    '{0, 3'b001, 32'h3003, 32'h0,        0, 0, 32'h0,         1, 4'b0000, 32'h0,    32'h0,        1},
    '{0, 3'b011, 32'h3000, 32'h0,        0, 0, 32'h0,         1, 4'b0000, 32'h0,    32'h0,        1},
    '{1, 3'b001, 32'h3001, 32'h0,        0, 0, 32'h0,         1, 4'b0000, 32'h0,    32'h0,        1},
    '{0, 3'b111, 32'h3000, 32'h0,        0, 0, 32'h0,         1, 4'b0000, 32'h0,    32'h0,        1},
    '{1, 3'b100, 32'h3000, 32'h0,        0, 0, 32'h0,         1, 4'b0000, 32'h0,    32'h0,        1}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int r0;
    #1;
    check("rst_outputs", {req_ready, resp_valid, resp_err, resp_rdata, mem_req, mem_we,
                          mem_be, mem_addr[15:0]}, '0);
    check("rst_mem_wdata", mem_wdata, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("ready_after_rst", req_ready, 1);

    foreach (vecs[i]) begin
      gnt_dly = vecs[i].gd;
      rv_dly  = vecs[i].rd;
      n0      = req_cnt;
      do_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wd, vecs[i].exp_rd,
             vecs[i].err, vecs[i].lat, 1);
      if (!vecs[i].err) begin
        @(negedge clk);
        check("mem_req", mem_req, 1);
        check("mem_addr", mem_addr, vecs[i].ma);
        check("mem_be", mem_be, vecs[i].be);
        check("mem_we", mem_we, vecs[i].we);
        if (vecs[i].we) check("mem_wdata", mem_wdata, vecs[i].mwd);
      end
      wait_idle();
      if (vecs[i].err) check("no_mem_req", req_cnt, n0);
    end

    // Grant stalled three cycles, read data never arrives.
    gnt_dly = 3;
    rv_dly  = -1;
    do_req(0, 3'b100, 32'h4000, 32'h0, 32'h0, 1, 2 + 3 + TO, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("stall_mem_req", mem_req, 1);
      check("stall_mem_addr", mem_addr, 32'h4000);
      check("stall_mem_be", mem_be, 4'b0001);
    end
    wait_idle();
    pending = 0;

    // Reset while waiting for read data; the late rvalid must be ignored.
    gnt_dly = 0;
    rv_dly  = -1;
    r0 = resp_cnt;
    do_req(0, 3'b010, 32'h1000, 32'h0, 32'h0, 0, 0, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_outputs", {req_ready, resp_valid, resp_err, resp_rdata, mem_req, mem_we,
                             mem_be, mem_addr[15:0]}, '0);
    @(negedge clk);
    pending = 0;
    reset_n = 1'b1;
    #1;
    check("midrst_ready", req_ready, 1);
    rv_dly  = 0;
    rv_cnt  = 0;
    pending = 1;
    repeat (5) @(negedge clk);
    check("midrst_no_resp", resp_cnt, r0);
    check("midrst_ready_idle", req_ready, 1);

    do64(3'b110, 64'h0000_0000_8765_4321);
    do64(3'b010, 64'hFFFF_FFFF_8765_4321);

    check("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
